shift_rate_controller: RTL and testbench
========================================

# shift_rate_controller

Parametrised successor to the fixed 4-bit shifter controller. It divides an enable-tick stream by a programmable period and issues one `shifterEn` per period. It counts shifts up to a programmable total and reports completion through a start/ready/done handshake. The block sits between the tick source and the datapath shift register, and supports an abort path and variable prescale and shift-count widths.

## Interface
- `CW`, 8: prescale counter width; the maximum period is 2^CW ticks.
- `SCW`, 5: shift counter width; the maximum shift total is 2^SCW − 1.
- `Clk`  in  1: rising-edge clock.
- `Reset`  in  1: asynchronous, active-low reset.
- `En`  in  1: tick qualifier; the prescaler advances only on cycles with `En`=1.
- `start`  in  1: begin a run; accepted only when `ready`=1.
- `abort`  in  1: synchronous cancel of a run in progress.
- `control`  in  1: mode select, latched at start. 0 = full period (2^CW ticks); 1 = programmable period.
- `m`  in  CW: period minus one, used in mode 1, latched at start.
- `n`  in  SCW: number of shifts in the run, latched at start.
- `shifterEn`  out  1: one-cycle shift strobe, combinational.
- `ready`  out  1: block idle and able to accept `start`.
- `done`  out  1: one-cycle pulse when a run completes normally.
- `shifts_done`  out  SCW: shifts issued in the current or last run.

## Operation
- States: IDLE and RUN.
- Reset values: state IDLE, `ready`=1, `done`=0, `shifterEn`=0, `shifts_done`=0, prescaler 0, latched `m`/`n`/`control` = 0.
- `ready` = (state == IDLE). `shifterEn` = (state == RUN) && `En` && (prescaler == term) && !`abort`.
  - term = all-ones when latched `control`=0.
  - term = latched `m` when latched `control`=1.
- IDLE → RUN: on `start`=1.
  - Latch `m`, `n`, `control`.
  - Clear the prescaler and `shifts_done`.
- IDLE → IDLE with `n`=0: on `start`=1 with `n`=0.
  - Latch the inputs and clear `shifts_done`.
  - Pulse `done` next cycle.
  - No shift is issued.
- In RUN, on each cycle with `En`=1:
  - If prescaler ≠ term, increment the prescaler.
  - If prescaler == term, clear it to 0 and assert `shifterEn`, which increments `shifts_done`.
- RUN → IDLE (normal completion): on the `shifterEn` cycle where `shifts_done` + 1 == latched `n`. Pulse `done` on the following cycle.
- RUN → IDLE (abort): on any cycle with `abort`=1.
  - No `done` pulse.
  - Any same-cycle `shifterEn` is suppressed, so abort wins over the final shift.
  - `shifts_done` holds its value.
- `abort` in IDLE: no effect.
- `start` in RUN: ignored. Input changes during RUN have no effect because all three inputs are latched.
- Counter widths: the prescaler compare is CW bits wide, and `shifts_done` is SCW bits. Neither counter wraps in RUN because the termination condition is checked before overflow.
- Mode 1 with `m`=0: `shifterEn` fires on every `En` tick.
- Asserting `Reset` mid-run forces reset values immediately, with no `done` pulse.

## Timing
- `start` sampled high at edge T: `ready`=0 from T+1. Prescaler counting begins with `En` ticks at T+1.
- First `shifterEn`: on the cycle of the (term+1)-th `En` tick after T.
- Final `shifterEn` at cycle F: `ready`=1 and `done`=1 at F+1, and `done`=0 at F+2.
- Back-to-back runs: a `start` high during the `done` cycle is accepted, and `ready` drops again at the next cycle.
- `shifterEn` is same-cycle with `En`, so the datapath shifts on the same edge that advances the controller.
- Latency from `start` to `done` with `En` held at 1: n × (term+1) + 1 cycles.

## Test plan
- Reset, then mode 1, `m`=2, `n`=3, `En`=1 continuously:
  - `shifterEn` pulses at cycles 3, 6 and 9 after start.
  - `done` pulses at cycle 10, then `ready`=1 and `shifts_done`=3.
- Mode 0, CW=4 variant, `n`=2, `En` toggling every other cycle:
  - `shifterEn` fires only on `En` cycles, on the 16th and 32nd tick.
  - `done` follows the second strobe by one cycle.
- Mode 1, `m`=0, `n`=5: `shifterEn` is high on five consecutive `En` cycles, then the `done` pulse follows.
- `n`=0 start: no `shifterEn`, `done` pulses one cycle later, and `ready` never drops.
- Abort cases, with `m`=3 and `n`=4:
  - `abort` after two shifts: IDLE next cycle, `shifts_done`=2, no `done`.
  - `abort` coincident with the fourth strobe: `shifterEn`=0 on that cycle, `shifts_done`=3, no `done`.
- `Reset` pulled low mid-run: all outputs return to reset values immediately. A `start` after reset release begins a clean run.

Source files
------------

// File: rtl/shift_rate_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// shift_rate_controller
//
// Divides a qualified tick stream (En) by a programmable period and issues one
// shifterEn strobe per period. It counts strobes up to a programmable total and
// reports completion through a start / ready / done handshake. A run can be
// cancelled with abort.
//
// Parameters
//   CW          prescaler width; full-period mode divides by 2^CW ticks
//   SCW         shift counter width; largest run is 2^SCW-1 shifts
//
// Ports
//   Clk         rising-edge clock
//   Reset       asynchronous active-low reset
//   En          tick qualifier; the prescaler only moves on En cycles
//   start       begin a run (accepted only while ready)
//   abort       cancel a run in progress (ignored while idle)
//   control     0 = period 2^CW ticks, 1 = period m+1 ticks (latched at start)
//   m           period minus one for control=1 (latched at start)
//   n           number of shifts in the run (latched at start)
//   shifterEn   one-cycle shift strobe, combinational, same cycle as its En tick
//   ready       idle, able to accept start
//   done        one-cycle pulse after the final shift of a normal run
//   shifts_done shifts issued in the current or last run
//
// FSM states
//   state | meaning
//   IDLE  | waiting for start; ready=1
//   RUN   | dividing En ticks and issuing shifts until n reached or abort
// -----------------------------------------------------------------------------
module shift_rate_controller #(
  parameter int CW  = 8,
  parameter int SCW = 5
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           En,
  input  logic           start,
  input  logic           abort,
  input  logic           control,
  input  logic [CW-1:0]  m,
  input  logic [SCW-1:0] n,
  output logic           shifterEn,
  output logic           ready,
  output logic           done,
  output logic [SCW-1:0] shifts_done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state;
  logic [CW-1:0]  presc;
  logic [CW-1:0]  m_q;
  logic [SCW-1:0] n_q;
  logic           ctrl_q;

  logic [CW-1:0]  term;
  logic           at_term;
  logic           last_shift;

  // Full-period mode terminates at all-ones so the period is exactly 2^CW.
  assign term       = ctrl_q ? m_q : {CW{1'b1}};
  assign at_term    = (presc == term);
  // The run ends on the strobe that brings the count up to n; checking this
  // before the increment keeps shifts_done from ever wrapping.
  assign last_shift = ((shifts_done + SCW'(1)) == n_q);

  // Abort suppresses a coincident strobe so a cancelled run never shifts on
  // its way out.
  assign shifterEn  = (state == RUN) && En && at_term && !abort;
  assign ready      = (state == IDLE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      presc       <= '0;
      m_q         <= '0;
      n_q         <= '0;
      ctrl_q      <= 1'b0;
      shifts_done <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_q         <= m;
            n_q         <= n;
            ctrl_q      <= control;
            presc       <= '0;
            shifts_done <= '0;
            // A zero-length run completes immediately without leaving IDLE.
            if (n == '0) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (En) begin
            if (at_term) begin
              presc       <= '0;
              shifts_done <= shifts_done + SCW'(1);
              if (last_shift) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end else begin
              presc <= presc + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rate_controller.sv
`timescale 1ns/1ps
module tb_shift_rate_controller;

  localparam int CW   = 4;
  localparam int SCW  = 5;
  localparam int MAXC = 400;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           En;
  logic           start;
  logic           abort;
  logic           control;
  logic [CW-1:0]  m;
  logic [SCW-1:0] n;
  logic           shifterEn;
  logic           ready;
  logic           done;
  logic [SCW-1:0] shifts_done;

  always #5 Clk = ~Clk;

  shift_rate_controller #(.CW(CW), .SCW(SCW)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .start(start), .abort(abort),
    .control(control), .m(m), .n(n), .shifterEn(shifterEn), .ready(ready),
    .done(done), .shifts_done(shifts_done)
  );

  int checks = 0;
  int passed = 0;

  // Per-cycle stimulus and expectations; index 0 is the start cycle.
  bit en_seq [MAXC];
  bit ab_seq [MAXC];
  bit exp_sen [MAXC];
  bit exp_done [MAXC];
  bit exp_ready [MAXC];
  int exp_sd [MAXC];
  bit obs_sen [MAXC];
  bit obs_done [MAXC];
  bit obs_ready [MAXC];
  int obs_sd [MAXC];

  // Reference: a shift happens on every P-th En tick, P = m+1 or 2^CW,
  // until n shifts or an abort; done is reported the cycle after the n-th.
  task automatic model_run(input bit ctrl, input int mm, input int nn, output int fin);
    int  p, ticks, shifts;
    bit  running, done_next;
    p = ctrl ? mm + 1 : (1 << CW);
    running = (nn != 0);
    done_next = (nn == 0);
    ticks = 0; shifts = 0; fin = 0;
    exp_sen[0] = 0; exp_done[0] = 0; exp_ready[0] = 1; exp_sd[0] = 0;
    for (int k = 1; k < MAXC; k++) begin
      exp_ready[k] = !running;
      exp_sd[k]    = shifts;
      exp_done[k]  = done_next;
      done_next    = 0;
      exp_sen[k]   = 0;
      if (running) begin
        if (ab_seq[k]) begin
          running = 0; fin = k;
        end else if (en_seq[k]) begin
          ticks++;
          if (ticks % p == 0) begin
            exp_sen[k] = 1;
            shifts++;
            if (shifts == nn) begin
              running = 0; done_next = 1; fin = k;
            end
          end
        end
      end
    end
  endtask

  // Drives one run (start at cycle 0) and records outputs mid-cycle.
  // After cycle 0 the config inputs are scrambled to show they are latched.
  task automatic exec_run(input bit ctrl, input int mm, input int nn, input int len);
    for (int k = 0; k < len; k++) begin
      if (k == 0) begin
        start = 1; control = ctrl; m = CW'(mm); n = SCW'(nn);
      end else begin
        start = 0; control = 1'($urandom_range(0, 1));
        m = CW'($urandom); n = SCW'($urandom);
      end
      En = en_seq[k];
      abort = ab_seq[k];
      @(negedge Clk);
      obs_sen[k]   = shifterEn;
      obs_done[k]  = done;
      obs_ready[k] = ready;
      obs_sd[k]    = int'(shifts_done);
      @(posedge Clk); #1;
    end
    start = 0; En = 0; abort = 0;
  endtask

  task automatic fill(input bit en_val, input bit alternate);
    for (int k = 0; k < MAXC; k++) begin
      en_seq[k] = alternate ? k[0] : en_val;
      ab_seq[k] = 0;
    end
  endtask

  task automatic test_reset;
    Reset = 0; En = 1; start = 0; abort = 0; control = 0; m = '0; n = '0;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
    checks++; if (shifterEn !== 1'b0) $display("FAIL reset_shifterEn got=%b exp=0", shifterEn); else passed++;
    checks++; if (shifts_done !== '0) $display("FAIL reset_shifts_done got=%0d exp=0", shifts_done); else passed++;
    Reset = 1; En = 0;
    @(posedge Clk); #1;
  endtask

  task automatic test_mode1_basic;
    int fin;
    fill(1, 0);
    model_run(1, 2, 3, fin);
    exec_run(1, 2, 3, fin + 2);
    for (int k = 1; k < fin + 2; k++) begin
      checks++;
      if ({obs_sen[k], obs_done[k], obs_ready[k], obs_sd[k]} !== {exp_sen[k], exp_done[k], exp_ready[k], exp_sd[k]})
        $display("FAIL mode1_basic cyc=%0d got sen/done/rdy/sd=%b%b%b/%0d exp=%b%b%b/%0d", k,
                 obs_sen[k], obs_done[k], obs_ready[k], obs_sd[k], exp_sen[k], exp_done[k], exp_ready[k], exp_sd[k]);
      else passed++;
    end
    checks++;
    if ({obs_sen[3], obs_sen[6], obs_sen[9], obs_done[10], obs_sd[10]} !== {1'b1, 1'b1, 1'b1, 1'b1, 32'd3})
      $display("FAIL mode1_points got sen3/6/9=%b%b%b done10=%b sd10=%0d exp 111 1 3",
               obs_sen[3], obs_sen[6], obs_sen[9], obs_done[10], obs_sd[10]);
    else passed++;
  endtask

  task automatic test_mode0_sparse;
    int fin;
    fill(0, 1);
    model_run(0, 0, 2, fin);
    exec_run(0, 0, 2, fin + 2);
    for (int k = 1; k < fin + 2; k++) begin
      checks++;
      if ({obs_sen[k], obs_done[k], obs_ready[k], obs_sd[k]} !== {exp_sen[k], exp_done[k], exp_ready[k], exp_sd[k]})
        $display("FAIL mode0_sparse cyc=%0d got sen/done/rdy/sd=%b%b%b/%0d exp=%b%b%b/%0d", k,
                 obs_sen[k], obs_done[k], obs_ready[k], obs_sd[k], exp_sen[k], exp_done[k], exp_ready[k], exp_sd[k]);
      else passed++;
    end
    checks++;
    if ({obs_sen[31], obs_sen[63], obs_done[64]} !== 3'b111)
      $display("FAIL mode0_points got sen31=%b sen63=%b done64=%b exp 111", obs_sen[31], obs_sen[63], obs_done[64]);
    else passed++;
  endtask

  task automatic test_m_zero;
    int fin;
    fill(1, 0);
    model_run(1, 0, 5, fin);
    exec_run(1, 0, 5, fin + 2);
    for (int k = 1; k < fin + 2; k++) begin
      checks++;
      if ({obs_sen[k], obs_done[k], obs_ready[k], obs_sd[k]} !== {exp_sen[k], exp_done[k], exp_ready[k], exp_sd[k]})
        $display("FAIL m_zero cyc=%0d got sen/done/rdy/sd=%b%b%b/%0d exp=%b%b%b/%0d", k,
                 obs_sen[k], obs_done[k], obs_ready[k], obs_sd[k], exp_sen[k], exp_done[k], exp_ready[k], exp_sd[k]);
      else passed++;
    end
    checks++;
    if ({obs_sen[1], obs_sen[2], obs_sen[3], obs_sen[4], obs_sen[5], obs_done[6]} !== 6'b111111)
      $display("FAIL m_zero_points got sen1..5=%b%b%b%b%b done6=%b exp 11111 1",
               obs_sen[1], obs_sen[2], obs_sen[3], obs_sen[4], obs_sen[5], obs_done[6]);
    else passed++;
  endtask

  task automatic test_n_zero;
    int fin;
    fill(1, 0);
    model_run(1, 0, 0, fin);
    exec_run(1, 0, 0, 4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_ready[k] !== 1'b1 || obs_sen[k] !== 1'b0)
        $display("FAIL n_zero_idle cyc=%0d got rdy=%b sen=%b exp rdy=1 sen=0", k, obs_ready[k], obs_sen[k]);
      else passed++;
    end
    checks++;
    if ({obs_done[1], obs_done[2], obs_sd[1]} !== {1'b1, 1'b0, 32'd0})
      $display("FAIL n_zero_done got done1=%b done2=%b sd1=%0d exp 1 0 0", obs_done[1], obs_done[2], obs_sd[1]);
    else passed++;
  endtask

  task automatic test_abort;
    int fin;
    int ab_cyc [2] = '{10, 16};
    int sd_exp [2] = '{2, 3};
    for (int c = 0; c < 2; c++) begin
      fill(1, 0);
      ab_seq[ab_cyc[c]] = 1;
      model_run(1, 3, 4, fin);
      exec_run(1, 3, 4, fin + 5);
      for (int k = 1; k < fin + 5; k++) begin
        checks++;
        if ({obs_sen[k], obs_done[k], obs_ready[k], obs_sd[k]} !== {exp_sen[k], exp_done[k], exp_ready[k], exp_sd[k]})
          $display("FAIL abort%0d cyc=%0d got sen/done/rdy/sd=%b%b%b/%0d exp=%b%b%b/%0d", c, k,
                   obs_sen[k], obs_done[k], obs_ready[k], obs_sd[k], exp_sen[k], exp_done[k], exp_ready[k], exp_sd[k]);
        else passed++;
      end
      checks++;
      if ({obs_sen[ab_cyc[c]], obs_ready[ab_cyc[c] + 1], obs_done[ab_cyc[c] + 1], obs_sd[ab_cyc[c] + 1]} !==
          {1'b0, 1'b1, 1'b0, sd_exp[c]})
        $display("FAIL abort%0d_points got sen=%b rdy=%b done=%b sd=%0d exp 0 1 0 %0d", c,
                 obs_sen[ab_cyc[c]], obs_ready[ab_cyc[c] + 1], obs_done[ab_cyc[c] + 1], obs_sd[ab_cyc[c] + 1], sd_exp[c]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    int fin;
    fill(1, 0);
    model_run(1, 1, 2, fin);
    exec_run(1, 1, 2, fin + 1);
    model_run(1, 1, 1, fin);
    exec_run(1, 1, 1, fin + 2);
    checks++;
    if ({obs_done[0], obs_ready[0], obs_ready[1]} !== 3'b110)
      $display("FAIL back_to_back got done0=%b rdy0=%b rdy1=%b exp 1 1 0", obs_done[0], obs_ready[0], obs_ready[1]);
    else passed++;
    for (int k = 1; k < fin + 2; k++) begin
      checks++;
      if ({obs_sen[k], obs_done[k], obs_ready[k], obs_sd[k]} !== {exp_sen[k], exp_done[k], exp_ready[k], exp_sd[k]})
        $display("FAIL back_to_back cyc=%0d got sen/done/rdy/sd=%b%b%b/%0d exp=%b%b%b/%0d", k,
                 obs_sen[k], obs_done[k], obs_ready[k], obs_sd[k], exp_sen[k], exp_done[k], exp_ready[k], exp_sd[k]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_run;
    int fin;
    fill(1, 0);
    model_run(1, 3, 4, fin);
    exec_run(1, 3, 4, 6);
    checks++;
    if ({obs_ready[5], obs_sd[5]} !== {1'b0, 32'd1})
      $display("FAIL pre_reset got rdy=%b sd=%0d exp 0 1", obs_ready[5], obs_sd[5]);
    else passed++;
    En = 1; abort = 0; start = 0;
    #2 Reset = 0;
    #1;
    checks++;
    if ({ready, done, shifterEn, shifts_done} !== {1'b1, 1'b0, 1'b0, SCW'(0)})
      $display("FAIL reset_mid_run got rdy=%b done=%b sen=%b sd=%0d exp 1 0 0 0", ready, done, shifterEn, shifts_done);
    else passed++;
    @(posedge Clk); #1;
    Reset = 1; En = 0;
    @(posedge Clk); #1;
    model_run(1, 2, 3, fin);
    exec_run(1, 2, 3, fin + 2);
    for (int k = 1; k < fin + 2; k++) begin
      checks++;
      if ({obs_sen[k], obs_done[k], obs_ready[k], obs_sd[k]} !== {exp_sen[k], exp_done[k], exp_ready[k], exp_sd[k]})
        $display("FAIL post_reset cyc=%0d got sen/done/rdy/sd=%b%b%b/%0d exp=%b%b%b/%0d", k,
                 obs_sen[k], obs_done[k], obs_ready[k], obs_sd[k], exp_sen[k], exp_done[k], exp_ready[k], exp_sd[k]);
      else passed++;
    end
  endtask

  task automatic test_random;
    int fin, mm, nn;
    bit ctrl;
    for (int it = 0; it < 25; it++) begin
      ctrl = 1'($urandom_range(0, 1));
      mm = $urandom_range(0, (1 << CW) - 1);
      nn = $urandom_range(0, 6);
      for (int k = 0; k < MAXC; k++) begin
        en_seq[k] = (k >= 250) ? 1'b1 : ($urandom_range(0, 3) != 0);
        ab_seq[k] = ($urandom_range(0, 79) == 0);
      end
      model_run(ctrl, mm, nn, fin);
      exec_run(ctrl, mm, nn, fin + 2);
      for (int k = 1; k < fin + 2; k++) begin
        checks++;
        if ({obs_sen[k], obs_done[k], obs_ready[k], obs_sd[k]} !== {exp_sen[k], exp_done[k], exp_ready[k], exp_sd[k]})
          $display("FAIL random it=%0d c=%0d m=%0d n=%0d cyc=%0d got sen/done/rdy/sd=%b%b%b/%0d exp=%b%b%b/%0d",
                   it, ctrl, mm, nn, k, obs_sen[k], obs_done[k], obs_ready[k], obs_sd[k],
                   exp_sen[k], exp_done[k], exp_ready[k], exp_sd[k]);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_mode1_basic;
    test_mode0_sparse;
    test_m_zero;
    test_n_zero;
    test_abort;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
